// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S / left-justified transmitter.
// Format selectors plus the serial frame-word width.
package i2s_pkg;

  localparam int FMT_I2S = 0;
  localparam int FMT_LJ  = 1;

  // One stereo frame is two slots, left first.
  function automatic int frame_w(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo sample pairs feeding the transmitter.
// The head entry is read combinationally so a pop can load the shifter on the same edge.
module i2s_sample_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified transmitter: BCK divider, frame counter, shifter
// and the optional one-BCK data delay, fed from a small sample-pair FIFO.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter  int DATA_W     = 24,
  parameter  int SLOT_W     = 32,
  parameter  int BCK_HALF   = 1,
  parameter  int FIFO_DEPTH = 4,
  parameter  int FMT        = 0,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              mute,
  output logic              underrun,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              i2s_lrck,
  output logic              i2s_bck,
  output logic              i2s_data
);

  localparam int FRAME_W = frame_w(SLOT_W);
  localparam int PAD_W   = SLOT_W - DATA_W;
  localparam int DIV_W   = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  logic [DIV_W-1:0]        div_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_next;
  logic [FRAME_W-1:0]      shift_reg;
  logic                    bck_reg;
  logic                    lrck_reg;
  logic                    dly_reg;
  logic                    underrun_reg;
  logic                    tick;
  logic                    fall;
  logic                    frame_start;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [2*DATA_W-1:0]     fifo_rd;
  logic [1:0][SLOT_W-1:0]  slot_word;
  logic [FRAME_W-1:0]      frame_word;

  i2s_sample_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s_valid),
    .pop     (frame_start),
    .wr_data ({s_left, s_right}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Slot 1 (left) lands in the upper half; samples are MSB-aligned in their slot.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign slot_word[gi] = SLOT_W'(fifo_rd[gi*DATA_W +: DATA_W]) << PAD_W;
  end
  assign frame_word = slot_word;

  always_comb begin
    tick         = (div_cnt_reg == DIV_W'(BCK_HALF - 1));
    fall         = tick && bck_reg;
    frame_start  = fall && (bit_cnt_reg == BIT_W'(FRAME_W - 1));
    bit_cnt_next = frame_start ? '0 : bit_cnt_reg + BIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg  <= '0;
      bck_reg      <= 1'b0;
      bit_cnt_reg  <= BIT_W'(FRAME_W - 1);
      lrck_reg     <= 1'b1;
      shift_reg    <= '0;
      dly_reg      <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      div_cnt_reg  <= tick ? '0 : div_cnt_reg + DIV_W'(1);
      underrun_reg <= frame_start && fifo_empty;
      if (tick) begin
        bck_reg <= !bck_reg;
      end
      if (fall) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= (bit_cnt_next >= BIT_W'(SLOT_W));
        // The delay flop captures the outgoing MSB, so the right LSB spills into period 0.
        dly_reg     <= shift_reg[FRAME_W-1];
        if (frame_start) begin
          shift_reg <= (fifo_empty || mute) ? '0 : frame_word;
        end else begin
          shift_reg <= shift_reg << 1;
        end
      end
    end
  end

  assign s_ready  = !fifo_full;
  assign underrun = underrun_reg;
  assign i2s_bck  = bck_reg;
  assign i2s_lrck = lrck_reg;
  assign i2s_data = (FMT == FMT_LJ) ? shift_reg[FRAME_W-1] : dly_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx: a left-justified DUT (DATA_W == SLOT_W) and an I2S DUT
// (padded slots) share stimulus and are compared every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_i2s_tx;

  localparam int S     = 8;
  localparam int BH    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = 2 * S;
  localparam int DW0   = 8;
  localparam int DW1   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_valid = 1'b0;
  logic       mute = 1'b0;
  logic [7:0] s_left = '0;
  logic [7:0] s_right = '0;

  logic [1:0] rdy, und, lrck, bck, dat;
  logic [2:0] lvl0, lvl1;

  int n_checks = 0;
  int n_fail = 0;

  // Model state
  int          n_edge = 0;
  int          push_idx = 0;
  int          frames = 0;
  logic [7:0]  ql[$];
  logic [7:0]  qr[$];
  logic [FW-1:0] cur_w[2];
  logic [FW-1:0] prev_w[2];
  logic        exp_und = 1'b0;

  i2s_tx #(.DATA_W(DW0), .SLOT_W(S), .BCK_HALF(BH), .FIFO_DEPTH(DEPTH), .FMT(1)) dut_lj (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy[0]),
    .s_left(s_left), .s_right(s_right), .mute(mute), .underrun(und[0]),
    .fifo_level(lvl0), .i2s_lrck(lrck[0]), .i2s_bck(bck[0]), .i2s_data(dat[0])
  );

  i2s_tx #(.DATA_W(DW1), .SLOT_W(S), .BCK_HALF(BH), .FIFO_DEPTH(DEPTH), .FMT(0)) dut_i2s (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy[1]),
    .s_left(s_left[DW1-1:0]), .s_right(s_right[DW1-1:0]), .mute(mute), .underrun(und[1]),
    .fifo_level(lvl1), .i2s_lrck(lrck[1]), .i2s_bck(bck[1]), .i2s_data(dat[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] make_word(input int dw, input logic [7:0] l, input logic [7:0] r);
    int mask = (1 << dw) - 1;
    int w = ((int'(l) & mask) << (2 * S - dw)) | ((int'(r) & mask) << (S - dw));
    return w[FW-1:0];
  endfunction

  task automatic model_reset();
    n_edge  = 0;
    exp_und = 1'b0;
    ql.delete();
    qr.delete();
    for (int d = 0; d < 2; d++) begin
      cur_w[d]  = '0;
      prev_w[d] = '0;
    end
  endtask

  // Advance the model across one rising edge, using the inputs driven before it.
  task automatic model_edge();
    bit         ready_pre;
    int         k, p;
    logic [7:0] l, r;
    ready_pre = (ql.size() < DEPTH);
    n_edge++;
    exp_und = 1'b0;
    if (n_edge % (2 * BH) == 0) begin
      k = n_edge / (2 * BH);
      p = (k - 1) % (2 * S);
      if (p == 0) begin
        for (int d = 0; d < 2; d++) prev_w[d] = cur_w[d];
        if (ql.size() == 0) begin
          cur_w[0] = '0;
          cur_w[1] = '0;
          exp_und  = 1'b1;
        end else begin
          l = ql.pop_front();
          r = qr.pop_front();
          cur_w[0] = mute ? '0 : make_word(DW0, l, r);
          cur_w[1] = mute ? '0 : make_word(DW1, l, r);
        end
        frames++;
        $display("frame %0d: underrun=%0b mute=%0b word_lj=%h word_i2s=%h level=%0d",
                 frames, exp_und, mute, cur_w[0], cur_w[1], ql.size());
      end
    end
    if (s_valid && ready_pre) begin
      ql.push_back(s_left);
      qr.push_back(s_right);
      push_idx++;
    end
  endtask

  task automatic check_outputs(input string ph);
    int   k, p;
    logic e_lrck;
    logic e_bck;
    logic [1:0] e_dat;
    e_bck = ((n_edge / BH) % 2) == 1;
    if (n_edge < 2 * BH) begin
      e_lrck = 1'b1;
      e_dat  = 2'b00;
    end else begin
      k = n_edge / (2 * BH);
      p = (k - 1) % (2 * S);
      e_lrck   = (p >= S);
      e_dat[0] = cur_w[0][FW-1-p];
      e_dat[1] = (p == 0) ? prev_w[1][0] : cur_w[1][FW-p];
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d bck", ph, d), 32'(bck[d]), 32'(e_bck));
      check($sformatf("%s dut%0d lrck", ph, d), 32'(lrck[d]), 32'(e_lrck));
      check($sformatf("%s dut%0d data", ph, d), 32'(dat[d]), 32'(e_dat[d]));
      check($sformatf("%s dut%0d underrun", ph, d), 32'(und[d]), 32'(exp_und));
      check($sformatf("%s dut%0d s_ready", ph, d), 32'(rdy[d]), 32'(ql.size() < DEPTH));
    end
    check($sformatf("%s dut0 level", ph), 32'(lvl0), 32'(ql.size()));
    check($sformatf("%s dut1 level", ph), 32'(lvl1), 32'(ql.size()));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input int vprob, input int mprob);
    s_valid = ($urandom_range(99) < vprob);
    mute    = ($urandom_range(99) < mprob);
    if (push_idx == 0) begin
      s_left  = 8'hA5;
      s_right = 8'h3C;
    end else if (push_idx == 1) begin
      s_left  = 8'h21;
      s_right = 8'hBF;
    end else begin
      s_left  = 8'($urandom);
      s_right = 8'($urandom);
    end
    @(posedge clk);
    #1;
    model_edge();
    check_outputs("run");
    @(negedge clk);
  endtask

  task automatic run_phase(input int ncyc, input int vprob, input int mprob);
    for (int c = 0; c < ncyc; c++) cycle(vprob, mprob);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_phase(200, 100, 0);   // fill, backpressure, directed first pairs
    run_phase(200, 0, 0);     // drain into underruns
    run_phase(330, 70, 25);   // mixed traffic with muted frames

    // Asynchronous reset between clock edges, mid-frame with data queued
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_phase(150, 100, 10);
    run_phase(300, 10, 0);
    run_phase(400, 60, 30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
